// File: rtl/answer_pkg.sv
// Shared key codes, entry states and field sizing for the
// keypad answer builder.
package answer_pkg;

  localparam int FIELD_DIGITS_DEF = 3;

  localparam logic [3:0] KEY_SEP   = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_BACK  = 4'hC;
  localparam logic [3:0] KEY_CLEAR = 4'hD;

  typedef enum logic [1:0] {
    ENTRY_A   = 2'd0,
    ENTRY_B   = 2'd1,
    SUBMITTED = 2'd2
  } state_t;

endpackage

// File: rtl/answer_entry_bcd_field.sv
// One answer factor: a shift register of BCD digits with a
// digit count.
module bcd_field #(
  parameter int N = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic           i_clr,
  input  logic [3:0]     i_d,
  output logic [4*N-1:0] o_field,
  output logic           o_full,
  output logic           o_empty
);

  localparam int CW = $clog2(N + 1);

  logic [4*N-1:0] r_field;
  logic [CW-1:0]  r_cnt;

  always_ff @(posedge CLK) begin
    if (RST || i_clr) begin
      r_field <= '0;
      r_cnt   <= '0;
    end else if (i_push) begin
      r_field <= {r_field[4*N-5:0], i_d};
      r_cnt   <= r_cnt + 1'b1;
    end else if (i_pop) begin
      r_field <= {4'h0, r_field[4*N-1:4]};
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  assign o_field = r_field;
  assign o_full  = (r_cnt == CW'(N));
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/answer_entry.sv
// Keypad answer builder: decodes keys into two BCD fields and
// latches the submitted {a, b} answer for the checker.
module answer_entry
  import answer_pkg::*;
#(
  parameter int FIELD_DIGITS = FIELD_DIGITS_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic                    new_q,
  output logic [8*FIELD_DIGITS-1:0] check_in,
  output logic [8*FIELD_DIGITS-1:0] entry,
  output logic [1:0]              state,
  output logic                    submit_pulse,
  output logic                    key_err
);

  localparam int W = 4 * FIELD_DIGITS;

  state_t r_state;
  state_t w_nxt;

  logic [2*W-1:0] r_check;
  logic           r_submit;
  logic           r_err;

  logic [W-1:0] w_fa;
  logic [W-1:0] w_fb;
  logic w_full_a, w_empty_a;
  logic w_full_b, w_empty_b;

  logic w_push_a, w_pop_a;
  logic w_push_b, w_pop_b;
  logic w_clr, w_err, w_submit;

  logic w_dig, w_sep, w_ent;
  logic w_bak, w_clk, w_rsv;
  logic w_zero;

  assign w_dig  = key_code <= 4'd9;
  assign w_sep  = key_code == KEY_SEP;
  assign w_ent  = key_code == KEY_ENTER;
  assign w_bak  = key_code == KEY_BACK;
  assign w_clk  = key_code == KEY_CLEAR;
  assign w_rsv  = key_code >= 4'hE;
  assign w_zero = ({w_fa, w_fb} == '0);

  // new_q overrides any key sampled on the same edge
  always_comb begin
    w_nxt    = r_state;
    w_push_a = 1'b0;
    w_pop_a  = 1'b0;
    w_push_b = 1'b0;
    w_pop_b  = 1'b0;
    w_clr    = 1'b0;
    w_err    = 1'b0;
    w_submit = 1'b0;
    if (new_q) begin
      w_clr = 1'b1;
      w_nxt = ENTRY_A;
    end else if (key_valid) begin
      unique case (1'b1)
        w_rsv: w_err = 1'b1;
        w_clk: begin
          w_clr = 1'b1;
          w_nxt = ENTRY_A;
        end
        w_dig: begin
          if (r_state == ENTRY_A) begin
            if (w_full_a) w_err = 1'b1;
            else w_push_a = 1'b1;
          end else if (r_state == ENTRY_B) begin
            if (w_full_b) w_err = 1'b1;
            else w_push_b = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        w_sep: begin
          if (r_state == ENTRY_A && !w_empty_a)
            w_nxt = ENTRY_B;
          else
            w_err = 1'b1;
        end
        w_bak: begin
          if (r_state == ENTRY_A) begin
            if (w_empty_a) w_err = 1'b1;
            else w_pop_a = 1'b1;
          end else if (r_state == ENTRY_B) begin
            if (w_empty_b) w_nxt = ENTRY_A;
            else w_pop_b = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        w_ent: begin
          if (r_state == ENTRY_B && !w_empty_b
              && !w_zero) begin
            w_submit = 1'b1;
            w_nxt    = SUBMITTED;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ENTRY_A;
      r_check  <= '0;
      r_submit <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_submit <= w_submit;
      r_err    <= w_err;
      if (w_clr)
        r_check <= '0;
      else if (w_submit)
        r_check <= {w_fa, w_fb};
    end
  end

  bcd_field #(.N(FIELD_DIGITS)) u_fa (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push_a),
    .i_pop   (w_pop_a),
    .i_clr   (w_clr),
    .i_d     (key_code),
    .o_field (w_fa),
    .o_full  (w_full_a),
    .o_empty (w_empty_a)
  );

  bcd_field #(.N(FIELD_DIGITS)) u_fb (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (w_push_b),
    .i_pop   (w_pop_b),
    .i_clr   (w_clr),
    .i_d     (key_code),
    .o_field (w_fb),
    .o_full  (w_full_b),
    .o_empty (w_empty_b)
  );

  assign check_in     = r_check;
  assign entry        = {w_fa, w_fb};
  assign state        = r_state;
  assign submit_pulse = r_submit;
  assign key_err      = r_err;

endmodule

// File: tb/tb_answer_entry.sv
// Directed bench for answer_entry with hand-computed
// expectations checked on the falling edge.
module tb_answer_entry;

  logic        CLK = 1'b0;
  logic        RST;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        new_q;
  logic [23:0] check_in;
  logic [23:0] entry;
  logic [1:0]  state;
  logic        submit_pulse;
  logic        key_err;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  answer_entry dut (
    .CLK          (CLK),
    .RST          (RST),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .new_q        (new_q),
    .check_in     (check_in),
    .entry        (entry),
    .state        (state),
    .submit_pulse (submit_pulse),
    .key_err      (key_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // drive at a falling edge, return at the next falling edge
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge CLK);
    key_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge CLK);
  endtask

  initial begin
    RST       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    new_q     = 1'b0;
    idle();
    idle();
    chk("rst_state", 32'(state), 0);
    chk("rst_entry", 32'(entry), 0);
    chk("rst_check", 32'(check_in), 0);
    chk("rst_err", 32'(key_err), 0);
    chk("rst_sub", 32'(submit_pulse), 0);
    RST = 1'b0;

    // 12 x 34
    press(4'h1);
    chk("d1_entry", 32'(entry), 32'h001000);
    press(4'h2);
    chk("d2_entry", 32'(entry), 32'h012000);
    press(4'hA);
    chk("sep_state", 32'(state), 1);
    press(4'h3);
    press(4'h4);
    chk("b_entry", 32'(entry), 32'h012034);
    chk("chk_pre", 32'(check_in), 0);
    press(4'hB);
    chk("ent_check", 32'(check_in), 32'h012034);
    chk("ent_sub", 32'(submit_pulse), 1);
    chk("ent_state", 32'(state), 2);
    chk("ent_err", 32'(key_err), 0);
    idle();
    chk("sub_1cyc", 32'(submit_pulse), 0);
    chk("chk_held", 32'(check_in), 32'h012034);
    press(4'hD);
    chk("clr_check", 32'(check_in), 0);
    chk("clr_entry", 32'(entry), 0);
    chk("clr_state", 32'(state), 0);
    chk("clr_err", 32'(key_err), 0);

    // overflow and back-out
    press(4'hA);
    chk("sep_empty_err", 32'(key_err), 1);
    chk("sep_empty_st", 32'(state), 0);
    press(4'h9);
    chk("err_1cyc", 32'(key_err), 0);
    press(4'h9);
    press(4'h9);
    press(4'h9);
    chk("ovf_err", 32'(key_err), 1);
    chk("ovf_entry", 32'(entry), 32'h999000);
    press(4'hC);
    chk("bk1_entry", 32'(entry), 32'h099000);
    press(4'hC);
    press(4'hA);
    chk("bk_sep_st", 32'(state), 1);
    press(4'hA);
    chk("sep_b_err", 32'(key_err), 1);
    press(4'hC);
    chk("bk_ret_st", 32'(state), 0);
    chk("bk_ret_ent", 32'(entry), 32'h009000);
    chk("bk_ret_err", 32'(key_err), 0);
    press(4'hC);
    chk("bk_last", 32'(entry), 0);
    chk("bk_last_err", 32'(key_err), 0);
    press(4'hC);
    chk("bk_empty_err", 32'(key_err), 1);

    // all-zero answer refused
    press(4'h0);
    press(4'hA);
    chk("lz_state", 32'(state), 1);
    press(4'h0);
    press(4'hB);
    chk("zero_err", 32'(key_err), 1);
    chk("zero_check", 32'(check_in), 0);
    chk("zero_state", 32'(state), 1);
    chk("zero_sub", 32'(submit_pulse), 0);

    // 7 x 11, then keys locked out
    press(4'hD);
    press(4'h7);
    press(4'hA);
    press(4'hB);
    chk("entb_empty", 32'(key_err), 1);
    press(4'h1);
    press(4'h1);
    press(4'hB);
    chk("s7_check", 32'(check_in), 32'h007011);
    press(4'h5);
    chk("sub_dig_err", 32'(key_err), 1);
    chk("sub_dig_chk", 32'(check_in), 32'h007011);
    chk("sub_dig_ent", 32'(entry), 32'h007011);
    chk("sub_dig_st", 32'(state), 2);
    new_q = 1'b1;
    idle();
    new_q = 1'b0;
    chk("nq_check", 32'(check_in), 0);
    chk("nq_state", 32'(state), 0);
    chk("nq_entry", 32'(entry), 0);

    // new_q beats a key on the same edge
    press(4'h5);
    chk("pre_nq", 32'(entry), 32'h005000);
    new_q = 1'b1;
    press(4'h3);
    new_q = 1'b0;
    chk("nqk_entry", 32'(entry), 0);
    chk("nqk_err", 32'(key_err), 0);
    press(4'hB);
    chk("ent_a_err", 32'(key_err), 1);

    // reserved codes
    press(4'h6);
    press(4'hE);
    chk("rsv_a_err", 32'(key_err), 1);
    chk("rsv_a_ent", 32'(entry), 32'h006000);
    chk("rsv_a_st", 32'(state), 0);
    press(4'hA);
    press(4'h2);
    press(4'hB);
    chk("s62_check", 32'(check_in), 32'h006002);
    press(4'hF);
    chk("rsv_s_err", 32'(key_err), 1);
    chk("rsv_s_chk", 32'(check_in), 32'h006002);
    chk("rsv_s_st", 32'(state), 2);

    // key_code ignored without key_valid
    key_code = 4'hE;
    idle();
    chk("novalid_err", 32'(key_err), 0);

    // reset mid-entry
    press(4'hD);
    press(4'h4);
    press(4'hA);
    press(4'h2);
    RST = 1'b1;
    press(4'h5);
    RST = 1'b0;
    chk("mrst_entry", 32'(entry), 0);
    chk("mrst_state", 32'(state), 0);
    chk("mrst_check", 32'(check_in), 0);
    chk("mrst_err", 32'(key_err), 0);

    // back-to-back strobes
    press(4'h1);
    chk("bb_first", 32'(entry), 32'h001000);
    press(4'hA);
    press(4'h1);
    press(4'hB);
    chk("bb_check", 32'(check_in), 32'h001001);
    chk("bb_sub", 32'(submit_pulse), 1);
    press(4'hD);
    chk("bb_clr", 32'(check_in), 0);
    chk("bb_clr_sub", 32'(submit_pulse), 0);
    press(4'h8);
    chk("bb_entry", 32'(entry), 32'h008000);
    chk("bb_err", 32'(key_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/answer_entry.md
# answer_entry

Keypad-side answer builder for the factorization game. It collects digit and command key codes, assembles a two-factor BCD answer, and presents it on `check_in` to the checker that drives the result LEDs. `check_in` stays all-zero until a valid answer is submitted, because the checker treats zero as "no answer yet" and holds its LED state.

## Interface
- `FIELD_DIGITS`, default 3: BCD digits per factor field. `check_in` width is 8*FIELD_DIGITS, which is 24 at the default.
- `CLK`  in  1  clock
- `RST`  in  1  synchronous, active-high reset
- `key_valid`  in  1  one-cycle strobe from the debounced keypad; `key_code` is sampled when this is high
- `key_code`  in  4  key codes:
  - 0x0–0x9: digit
  - 0xA: SEP
  - 0xB: ENTER
  - 0xC: BACK
  - 0xD: CLEAR
  - 0xE, 0xF: reserved
- `new_q`  in  1  one-cycle pulse marking a new question; aborts any entry in progress
- `check_in`  out  24  submitted answer {field_a, field_b}; 0 while nothing is submitted
- `entry`  out  24  live {field_a, field_b} for the 7-segment display
- `state`  out  2  current state: 0 ENTRY_A, 1 ENTRY_B, 2 SUBMITTED
- `submit_pulse`  out  1  high for one cycle on the edge where `check_in` is loaded
- `key_err`  out  1  high for one cycle when a sampled key is rejected

## Operation
- All outputs are registered.
- Reset values: state = ENTRY_A; `check_in`, `entry` and both digit counts = 0; `submit_pulse` = 0; `key_err` = 0.
- Digit entry: a digit shifts into the active field as field <= {field[4*FIELD_DIGITS-5:0], d} and increments that field's count.
  - If the count is already FIELD_DIGITS, the digit is rejected with `key_err` and the field is unchanged.
  - Leading zeros count as digits.
- ENTRY_A (active field is field_a):
  - Digit: enter as above.
  - SEP with cnt_a ≥ 1: go to ENTRY_B. SEP with cnt_a = 0: `key_err`.
  - BACK with cnt_a ≥ 1: field_a >>= 4, cnt_a −1. BACK with cnt_a = 0: `key_err`.
  - ENTER: `key_err`.
- ENTRY_B (active field is field_b):
  - Digit: enter as above.
  - SEP: `key_err`.
  - BACK with cnt_b ≥ 1: remove the last digit of field_b. BACK with cnt_b = 0: return to ENTRY_A; field_a is kept.
  - ENTER with cnt_b ≥ 1 and {field_a, field_b} ≠ 0: load `check_in`, assert `submit_pulse`, go to SUBMITTED.
  - ENTER with cnt_b = 0, or with an all-zero answer: `key_err`, state unchanged.
- SUBMITTED:
  - Digit, SEP, BACK and ENTER: `key_err`.
  - `check_in` and `entry` are held.
- CLEAR, from any state: zero both fields and both counts, zero `check_in`, go to ENTRY_A. No error.
- Reserved codes 0xE/0xF: `key_err` in every state, nothing else changes.
- `new_q`: same effect as CLEAR.
  - If `new_q` and `key_valid` are high on the same edge, `new_q` wins and the key is discarded with no `key_err`.
- If `RST` and any other input are high on the same edge, `RST` wins.
- Bits of `key_code` with `key_valid` low are ignored.

## Timing
- One key is processed per cycle. Back-to-back `key_valid` strobes are legal.
- Key latency: the key is sampled at edge N; `entry`, `state`, `key_err` and `submit_pulse` reflect it after edge N.
- `check_in` changes only on the ENTER edge, or on the CLEAR/`new_q`/RST edge, where it goes to 0.
- The checker samples `check_in` one cycle later. Its result therefore updates 2 cycles after the ENTER strobe; that delay belongs to the checker.
- `submit_pulse` and `key_err` are never high on the same cycle, and each lasts exactly one cycle.
- Reset mid-entry discards everything. The first key after `RST` deasserts is processed normally.

## Structure
- Shared package `answer_pkg` holds:
  - key code localparams: KEY_SEP, KEY_ENTER, KEY_BACK, KEY_CLEAR
  - state enum: ENTRY_A, ENTRY_B, SUBMITTED
  - FIELD_DIGITS default
- Sub-module `bcd_field`: a FIELD_DIGITS-deep 4-bit shift register with a count.
  - Commands: push / pop / clr.
  - Status flags: full / empty.
  - Instantiated twice, once per field.
- The top module holds the FSM, key decode, the `check_in` register and the pulse outputs.

## Test plan
- RST, then keys 1,2,SEP,3,4,ENTER -> `check_in` = 0x012034, `submit_pulse` for one cycle, `state` = 2, no `key_err`.
- Keys 9,9,9,9 -> fourth digit gives `key_err`, `entry` = 0x999000. Then BACK,BACK,SEP,BACK -> `entry` = 0x009000, `state` = 0 with cnt_a = 1.
- Keys 0,SEP,0,ENTER -> `key_err` on ENTER, `check_in` stays 0, `state` = 1.
- Submit 7×11, then key 5 in SUBMITTED -> `key_err`, `check_in` = 0x007011 held. Then `new_q` -> `check_in` = 0, `state` = 0.
- `new_q` and `key_valid` with digit 3 on the same edge -> `entry` = 0, no `key_err`. ENTER in ENTRY_A -> `key_err`. Reserved code 0xE in any state -> `key_err`, `entry`, `state` and `check_in` unchanged.
- `RST` asserted mid-entry after 4,SEP,2 -> all outputs 0 on the next cycle. Six back-to-back strobes 1,SEP,1,ENTER,CLEAR,8 -> `check_in` = 0x001001 then 0, final `entry` = 0x008000.
